instr_fetch: RTL and testbench

INSTR_FETCH -- requirements
Module: instr_fetch

---
 rtl/instr_fetch_pkg.sv | 26 ++
 rtl/instr_fetch_pc_next_mux.sv | 21 ++
 rtl/instr_fetch.sv | 132 +++++++++++++
 tb/tb_instr_fetch.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/instr_fetch_pkg.sv
// Shared fetch/decode definitions: LDM opcode, NOP word, fetch state encoding
// and next-PC select codes.
package instr_fetch_pkg;

    localparam logic [4:0]  OP_LDM = 5'b10101;
    localparam logic [15:0] NOP    = 16'h0000;

    typedef enum logic [1:0] {
        RST_LO = 2'b00,
        RST_HI = 2'b01,
        RUN    = 2'b10,
        IMM    = 2'b11
    } fetch_state_e;

    typedef enum logic [1:0] {
        PC_INC   = 2'b00,
        PC_JMP   = 2'b01,
        PC_STACK = 2'b10,
        PC_HOLD  = 2'b11
    } pc_sel_e;

    function automatic logic is_ldm(input logic [4:0] opcode);
        return opcode == OP_LDM;
    endfunction

endpackage

// File: rtl/instr_fetch_pc_next_mux.sv
// Combinational next-PC target selection; PC+1 wraps naturally at 32 bits.
module pc_next_mux
    import instr_fetch_pkg::*;
(
    input  logic [31:0] pc,
    input  logic [1:0]  pc_sel,
    input  logic [31:0] pc_jmp,
    input  logic [31:0] pc_stack,
    output logic [31:0] target
);

    always_comb begin
        unique case (pc_sel_e'(pc_sel))
            PC_INC:   target = pc + 32'd1;
            PC_JMP:   target = pc_jmp;
            PC_STACK: target = pc_stack;
            PC_HOLD:  target = pc;
        endcase
    end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch stage: two-word reset vector load, IF/ID register,
// LDM immediate tracking and interrupt entry.
module instr_fetch
    import instr_fetch_pkg::*;
#(
    parameter int          width = 16,
    parameter logic [31:0] IVEC  = 32'h0000_0020
) (
    input  logic             clk,
    input  logic             rst,
    output logic [31:0]      imem_addr,
    input  logic [width-1:0] imem_data,
    input  logic [1:0]       pc_sel,
    input  logic [31:0]      pc_jmp,
    input  logic [31:0]      pc_stack,
    input  logic             stall,
    input  logic             flush,
    input  logic             interrupt,
    output logic [width-1:0] instruction,
    output logic [31:0]      pc_next,
    output logic             ldm_value,
    output logic             fetch_valid,
    output logic             int_taken,
    output logic [31:0]      int_pc
);

    fetch_state_e     state_q, state_d;
    logic [31:0]      pc_q, pc_d;
    logic             int_pending_q, int_pending_d;
    logic [width-1:0] instr_q, instr_d;
    logic [31:0]      pc_next_q, pc_next_d;
    logic             ldm_q, ldm_d;
    logic             valid_q, valid_d;
    logic             int_taken_q, int_taken_d;
    logic [31:0]      int_pc_q, int_pc_d;
    logic [31:0]      target;

    pc_next_mux u_pc_next_mux (
        .pc       (pc_q),
        .pc_sel   (pc_sel),
        .pc_jmp   (pc_jmp),
        .pc_stack (pc_stack),
        .target   (target)
    );

    always_comb begin
        // NOTE: every output of this block gets a default first so no path infers a latch.
        state_d       = state_q;
        pc_d          = pc_q;
        int_pending_d = int_pending_q | interrupt;
        instr_d       = instr_q;
        pc_next_d     = pc_next_q;
        ldm_d         = ldm_q;
        valid_d       = valid_q;
        int_taken_d   = 1'b0;
        int_pc_d      = int_pc_q;
        imem_addr     = pc_q;

        unique case (state_q)
            RST_LO: begin
                imem_addr  = 32'd0;
                pc_d[15:0] = 16'(imem_data);
                state_d    = RST_HI;
            end
            RST_HI: begin
                imem_addr   = 32'd1;
                pc_d[31:16] = 16'(imem_data);
                state_d     = RUN;
            end
            RUN, IMM: begin
                if (flush) begin
                    instr_d = width'(NOP);
                    valid_d = 1'b0;
                    ldm_d   = 1'b0;
                    state_d = RUN;
                    pc_d    = target;
                end else if (stall) begin
                    // Freeze: PC, IF/ID and state keep their defaults.
                end else if (state_q == RUN && int_pending_q) begin
                    // Never in IMM, so an LDM opcode/immediate pair stays together.
                    pc_d          = IVEC;
                    int_pc_d      = pc_q;
                    int_taken_d   = 1'b1;
                    instr_d       = width'(NOP);
                    valid_d       = 1'b0;
                    ldm_d         = 1'b0;
                    int_pending_d = 1'b0;
                end else begin
                    instr_d   = imem_data;
                    pc_next_d = pc_q + 32'd1;
                    valid_d   = 1'b1;
                    ldm_d     = (state_q == IMM);
                    pc_d      = target;
                    state_d   = (state_q == RUN && is_ldm(imem_data[width-1 -: 5])) ? IMM : RUN;
                end
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= RST_LO;
            pc_q          <= '0;
            int_pending_q <= 1'b0;
            instr_q       <= '0;
            pc_next_q     <= '0;
            ldm_q         <= 1'b0;
            valid_q       <= 1'b0;
            int_taken_q   <= 1'b0;
            int_pc_q      <= '0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            int_pending_q <= int_pending_d;
            instr_q       <= instr_d;
            pc_next_q     <= pc_next_d;
            ldm_q         <= ldm_d;
            valid_q       <= valid_d;
            int_taken_q   <= int_taken_d;
            int_pc_q      <= int_pc_d;
        end
    end

    assign instruction = instr_q;
    assign pc_next     = pc_next_q;
    assign ldm_value   = ldm_q;
    assign fetch_valid = valid_q;
    assign int_taken   = int_taken_q;
    assign int_pc      = int_pc_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed plus randomized bench for instr_fetch against a behavioural
// fetch-stage model built from the stage's rules.
module tb_instr_fetch;

    localparam logic [4:0]  LDM_OP = 5'b10101;
    localparam logic [31:0] VEC    = 32'h0000_0020;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] imem_addr;
    logic [15:0] imem_data;
    logic [1:0]  pc_sel;
    logic [31:0] pc_jmp, pc_stack;
    logic        stall, flush, interrupt;
    logic [15:0] instruction;
    logic [31:0] pc_next;
    logic        ldm_value, fetch_valid, int_taken;
    logic [31:0] int_pc;

    logic [15:0] mem [256];

    int checks   = 0;
    int failures = 0;

    // Reference model state
    int          boot;
    bit          m_imm;
    logic [31:0] m_pc;
    bit          m_pend;
    logic [15:0] e_instr;
    logic [31:0] e_pcn, e_int_pc;
    bit          e_valid, e_ldm, e_taken;

    always #5 clk = ~clk;

    assign imem_data = mem[imem_addr[7:0]];

    instr_fetch #(.width(16), .IVEC(VEC)) dut (
        .clk         (clk),
        .rst         (rst),
        .imem_addr   (imem_addr),
        .imem_data   (imem_data),
        .pc_sel      (pc_sel),
        .pc_jmp      (pc_jmp),
        .pc_stack    (pc_stack),
        .stall       (stall),
        .flush       (flush),
        .interrupt   (interrupt),
        .instruction (instruction),
        .pc_next     (pc_next),
        .ldm_value   (ldm_value),
        .fetch_valid (fetch_valid),
        .int_taken   (int_taken),
        .int_pc      (int_pc)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] e_addr();
        if (boot == 0) return 32'd0;
        if (boot == 1) return 32'd1;
        return m_pc;
    endfunction

    task automatic model_reset();
        boot = 0; m_imm = 0; m_pc = 0; m_pend = 0;
        e_instr = 0; e_pcn = 0; e_int_pc = 0;
        e_valid = 0; e_ldm = 0; e_taken = 0;
    endtask

    task automatic model_edge();
        logic [31:0] tgt;
        logic [15:0] w;
        bit accept;
        accept  = 0;
        e_taken = 0;
        case (pc_sel)
            2'd0:    tgt = m_pc + 32'd1;
            2'd1:    tgt = pc_jmp;
            2'd2:    tgt = pc_stack;
            default: tgt = m_pc;
        endcase
        if (boot == 0) begin
            m_pc[15:0] = mem[0];
            boot = 1;
        end else if (boot == 1) begin
            m_pc[31:16] = mem[1];
            boot = 2;
        end else if (flush) begin
            e_instr = 0; e_valid = 0; e_ldm = 0;
            m_imm = 0; m_pc = tgt;
        end else if (stall) begin
            accept = 0;
        end else if (m_pend && !m_imm) begin
            accept = 1; e_taken = 1;
            e_int_pc = m_pc; m_pc = VEC;
            e_instr = 0; e_valid = 0; e_ldm = 0;
        end else begin
            w = mem[m_pc[7:0]];
            e_instr = w; e_pcn = m_pc + 32'd1;
            e_valid = 1; e_ldm = m_imm;
            m_imm = !m_imm && (w[15:11] == LDM_OP);
            m_pc = tgt;
        end
        m_pend = accept ? 1'b0 : (m_pend || interrupt);
    endtask

    task automatic step();
        check("imem_addr", imem_addr, e_addr());
        @(posedge clk);
        model_edge();
        #1;
        check("instruction", 32'(instruction), 32'(e_instr));
        check("fetch_valid", 32'(fetch_valid), 32'(e_valid));
        check("ldm_value", 32'(ldm_value), 32'(e_ldm));
        check("int_taken", 32'(int_taken), 32'(e_taken));
        check("int_pc", int_pc, e_int_pc);
        if (e_valid) check("pc_next", pc_next, e_pcn);
    endtask

    task automatic reset_check(input string tag);
        check({tag, "_instruction"}, 32'(instruction), 32'h0);
        check({tag, "_pc_next"}, pc_next, 32'h0);
        check({tag, "_ldm_value"}, 32'(ldm_value), 32'h0);
        check({tag, "_fetch_valid"}, 32'(fetch_valid), 32'h0);
        check({tag, "_int_taken"}, 32'(int_taken), 32'h0);
        check({tag, "_int_pc"}, int_pc, 32'h0);
        check({tag, "_imem_addr"}, imem_addr, 32'h0);
    endtask

    task automatic do_reset(input string tag);
        rst = 1'b0;
        #1;
        model_reset();
        reset_check(tag);
        #3;
        rst = 1'b1;
    endtask

    initial begin
        rst = 1'b0; stall = 0; flush = 0; interrupt = 0;
        pc_sel = 2'd0; pc_jmp = 0; pc_stack = 0;
        foreach (mem[i]) mem[i] = 16'($urandom);
        mem[0]     = 16'h0010;
        mem[1]     = 16'h0000;
        mem[8'h10] = {LDM_OP, 11'h000};
        mem[8'h11] = 16'hBEEF;
        mem[8'h20] = 16'h1234;
        mem[8'h21] = 16'h2345;
        mem[8'hFF] = 16'h0001;
        model_reset();

        #12;
        reset_check("por");
        rst = 1'b1;

        // Reset vector load
        step(); step();
        check("boot_pc", imem_addr, 32'h10);

        // LDM pair with interrupt arriving during the immediate word
        step();
        check("ldm_opcode", 32'(instruction), {16'h0, LDM_OP, 11'h000});
        interrupt = 1'b1;
        step();
        interrupt = 1'b0;
        check("ldm_imm_word", 32'(instruction), 32'hBEEF);
        check("ldm_flag", 32'(ldm_value), 32'h1);
        check("no_int_in_imm", 32'(int_taken), 32'h0);
        step();
        check("int_accept", 32'(int_taken), 32'h1);
        check("int_saved_pc", int_pc, 32'h12);
        check("int_vector", imem_addr, VEC);

        // Stall for three cycles, then resume
        step();
        stall = 1'b1;
        repeat (3) step();
        check("stall_addr", imem_addr, 32'h21);
        check("stall_instr", 32'(instruction), 32'h1234);
        stall = 1'b0;
        step();
        check("resume_instr", 32'(instruction), 32'h2345);
        check("resume_pc_next", pc_next, 32'h22);

        // Flush beats a simultaneous stall
        flush = 1'b1; stall = 1'b1; pc_sel = 2'd1; pc_jmp = 32'h40;
        step();
        flush = 1'b0; stall = 1'b0; pc_sel = 2'd0;
        check("flush_instr", 32'(instruction), 32'h0);
        check("flush_valid", 32'(fetch_valid), 32'h0);
        check("flush_target", imem_addr, 32'h40);

        // Asynchronous reset while in the immediate state
        do_reset("reboot");
        step(); step(); step();
        #2;
        rst = 1'b0;
        #1;
        reset_check("mid_imm");
        model_reset();
        #2;
        rst = 1'b1;
        step(); step();
        check("restart_pc", imem_addr, 32'h10);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            if (i == 200) begin
                do_reset("rand_rst");
            end
            flush     = ($urandom_range(7) == 0);
            stall     = ($urandom_range(4) == 0);
            interrupt = ($urandom_range(15) == 0);
            pc_sel    = 2'($urandom_range(3));
            pc_jmp    = 32'($urandom_range(255));
            pc_stack  = 32'($urandom_range(255));
            step();
        end
        flush = 0; stall = 0; interrupt = 0; pc_sel = 2'd0;

        // 32-bit PC wrap
        mem[0] = 16'hFFFF;
        mem[1] = 16'hFFFF;
        do_reset("wrap_rst");
        step(); step();
        check("wrap_top", imem_addr, 32'hFFFF_FFFF);
        step();
        check("wrap_zero", imem_addr, 32'h0);
        check("wrap_pc_next", pc_next, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
